// File: rtl/l2_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_req_ctrl
// Brief    : Single-outstanding request controller between an L2 cache and
//            main memory. It range-checks the address, issues one memory
//            request, times it out, and drains a stale memory ready.
// Revision : 1.0 - initial release
// ============================================================================
module l2_mem_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 65536,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_req_valid,
  input  logic              l2_req_rw,
  input  logic [ADDR_W-1:0] l2_req_addr,
  input  logic [DATA_W-1:0] l2_req_wdata,
  output logic              l2_req_ready,
  output logic              l2_resp_valid,
  output logic [DATA_W-1:0] l2_resp_rdata,
  output logic              l2_resp_err,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] main_memory_data_from_l2,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] main_memory_data_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  // Counter is sized for the largest legal TIMEOUT (1023).
  localparam logic [9:0]      c_CNT_LAST = 10'(TIMEOUT - 1);
  // One extra bit so a depth equal to 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        r_state;
  logic [9:0]        r_cnt;
  logic              r_aerr;
  logic              r_mem_valid;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic w_accept;
  logic w_addr_bad;
  logic w_done;
  logic w_tmo;

  assign w_accept   = l2_req_valid && (r_state == c_IDLE);
  assign w_addr_bad = ({1'b0, l2_req_addr} >= c_DEPTH);
  // Memory completion wins over a timeout landing in the same cycle.
  assign w_done     = (r_state == c_ISSUE) && mem_req_ready;
  assign w_tmo      = (r_state == c_ISSUE) && !mem_req_ready && (r_cnt == c_CNT_LAST);

  assign l2_req_ready             = (r_state == c_IDLE);
  assign l2_resp_valid            = r_resp_valid;
  assign l2_resp_rdata            = r_resp_rdata;
  assign l2_resp_err              = r_resp_err;
  assign mem_req_valid            = r_mem_valid;
  assign mem_req_rw               = r_mem_rw;
  assign mem_addr                 = r_mem_addr;
  assign main_memory_data_from_l2 = r_mem_wdata;

  // State sequencing and the ISSUE cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 10'd0;
      r_aerr  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 10'd0;
            r_aerr  <= w_addr_bad;
            r_state <= w_addr_bad ? c_RESP : c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_cnt <= r_cnt + 10'd1;
          if (w_done || w_tmo) begin
            r_state <= c_RESP;
          end
        end
        c_RESP: begin
          // An address error never touched memory, so there is nothing to drain.
          r_state <= r_aerr ? c_IDLE : c_DRAIN;
        end
        c_DRAIN: begin
          // Wait out the ready still held from the finished request.
          if (!mem_req_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Registered memory-side request and L2-side response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid  <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_mem_rw    <= l2_req_rw;
        r_mem_addr  <= l2_req_addr;
        r_mem_wdata <= l2_req_wdata;
        r_mem_valid <= !w_addr_bad;
        if (w_addr_bad) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
        end
      end else if (w_done) begin
        r_mem_valid  <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= r_mem_rw ? '0 : main_memory_data_o;
      end else if (w_tmo) begin
        r_mem_valid  <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire
